vga_fb_reader: RTL
==================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL provide parameter SRC_W, default 320, meaning source frame width in pixels.
REQ-002 SHALL provide parameter SRC_H, default 240, meaning source frame height in lines.
REQ-003 SHALL provide parameter ADDR_W, default 17, meaning frame-buffer address width.
REQ-004 SHALL provide parameter RD_LAT, default 1, range 1..3, meaning frame-buffer read latency in clk cycles.
REQ-005 SHALL provide port clk  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-006 SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL provide ports DE in 1, x_pixel in 10, y_pixel in 10  VGA display-enable and pixel coordinates.
REQ-008 SHALL provide port scale_sel  in  1  0 = 1:1 window at top-left, 1 = 2x upscale (each source pixel 2x2).
REQ-009 SHALL provide port tp_en  in  1  test-pattern request (see Configuration).
REQ-010 SHALL provide ports den out 1, rAddr out ADDR_W, rData in 16  frame-buffer read enable, address, RGB565 data.
REQ-011 SHALL provide port de_o  out  1  DE delayed to align with colour outputs.
REQ-012 SHALL provide ports r_port, g_port, b_port  out  4 each  colour outputs.

Function
REQ-013 SHALL register scale_sel into scale_q only on the cycle DE=1, x_pixel=0, y_pixel=0; mid-frame changes ignored until next frame.
REQ-014 SHALL define s = scale_q; window active when DE && x_pixel < (SRC_W<<s) && y_pixel < (SRC_H<<s).
REQ-015 SHALL register den = window active and rAddr = (y_pixel>>s)*SRC_W + (x_pixel>>s) one cycle after the x/y sample (stage 1).
REQ-016 SHALL drive rAddr = 0 (never Z) whenever den = 0.
REQ-017 SHALL compute rAddr with a line-base register advanced by SRC_W at line starts (every line for s=0, every second line for s=1) plus column offset; no multiplier.
REQ-018 SHALL treat rData as valid RD_LAT cycles after the rAddr it answers.
REQ-019 SHALL register colours at total latency L = RD_LAT+2 from the x/y sample: {r,g,b} = {rData[15:12], rData[10:7], rData[4:1]} if the delayed den is 1, else 0.
REQ-020 SHALL delay DE by exactly L cycles onto de_o through a shift register also carrying den.
REQ-021 SHALL output black, but still follow DE on de_o, for active pixels outside the window (e.g. x>=320 with s=0).
REQ-022 SHALL make address arithmetic ADDR_W wide; maximum address SRC_W*SRC_H-1 never wraps for default parameters.
REQ-023 SHALL output back-to-back pixels at one pixel per cycle with no bubbles.

Reset
REQ-024 SHALL on reset clear den, rAddr, de_o, r/g/b_port, all pipeline stages, line base, and scale_q (=0) in the same cycle.
REQ-025 SHALL, after reset deasserts mid-frame, keep den=0 and colours black until the next frame start (x=0, y=0, DE=1).

Configuration
REQ-026 SHALL honour macro VGA_FB_TESTPATTERN_EN: when defined and tp_en=1, den forced 0, colours = 8 vertical bars by x_pixel[8:6] (bit0->r=F, bit1->g=F, bit2->b=F, else 0) over all DE pixels at latency L.
REQ-027 SHALL, when VGA_FB_TESTPATTERN_EN is undefined, ignore tp_en and contain no pattern logic.

Structure
REQ-028 SHALL place pixel-format constants (RGB565 field positions), the 640x480 active-area constants and the bar colour table in shared package vga_pkg.
REQ-029 SHALL implement the L-stage DE/den delay as sub-module vga_delay_line (parameters WIDTH, DEPTH).

Verification
REQ-030 SHALL test s=0, RD_LAT=1: x=5, y=2, DE=1 -> rAddr=645, den=1 at +1; with rData=16'hF81F, r=F, g=0, b=F, de_o=1 at +3.
REQ-031 SHALL test s=1: x=639, y=479 -> rAddr=76799 (319+239*320), den=1; x=2 and x=3 on y=1 -> same rAddr=1.
REQ-032 SHALL test s=0, x=400, y=10, DE=1 -> den=0, rAddr=0, colours 0, de_o=1 at +3.
REQ-033 SHALL test scale_sel toggled at y=100 -> addressing unchanged until next x=0,y=0, then new scale applied.
REQ-034 SHALL test reset asserted at y=50 -> all outputs 0 next cycle; after release, den stays 0 until frame start.
REQ-035 SHALL test, with VGA_FB_TESTPATTERN_EN defined and tp_en=1, x=64 -> r=F, g=0, b=0; x=448 -> r=F, g=F, b=F; den=0 throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: RGB565 field positions, 640x480 active area,
// and the eight-bar test-pattern colour table.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // MSB of each RGB565 field; the top four bits of each field are kept
    localparam int R_HI = 15;
    localparam int G_HI = 10;
    localparam int B_HI = 4;

    // {r,g,b} nibbles indexed by bar number: bit0->r, bit1->g, bit2->b
    localparam logic [7:0][11:0] BAR_RGB = {
        12'hFFF, 12'h0FF, 12'hF0F, 12'h00F,
        12'hFF0, 12'h0F0, 12'hF00, 12'h000
    };

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
        return {d[R_HI-:4], d[G_HI-:4], d[B_HI-:4]};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous clear, used to align
// DE/den with the frame-buffer read data.
module vga_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer reader: VGA x/y to RGB565 fetch, 1:1 or 2x upscale.
// Optional colour-bar generator enabled by macro VGA_FB_TESTPATTERN_EN.
module vga_fb_reader
    import vga_pkg::*;
#(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DE,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              scale_sel,
    input  logic              tp_en,
    output logic              den,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [15:0]       rData,
    output logic              de_o,
    output logic [3:0]        r_port,
    output logic [3:0]        g_port,
    output logic [3:0]        b_port
);

`ifdef VGA_FB_TESTPATTERN_EN
    localparam int DL_W = 6;
`else
    localparam int DL_W = 2;
`endif

    logic              scale_q, scale_d;
    logic              frame_ok_q, frame_ok_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              den_q, den_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              de_o_q, de_o_d;
    logic [11:0]       rgb_q, rgb_d;

    logic              frame_start;
    logic              line_start;
    logic              row_adv;
    logic              in_win;
    logic              active;
    logic              tp;
    logic [11:0]       w_lim;
    logic [11:0]       h_lim;
    logic [9:0]        col;
    logic [DL_W-1:0]   dl_in;
    logic [DL_W-1:0]   dl_out;

`ifdef VGA_FB_TESTPATTERN_EN
    assign tp = tp_en;
`else
    logic unused_tp;
    assign tp        = 1'b0;
    assign unused_tp = tp_en;
`endif

    always_comb begin
        frame_start = DE && (x_pixel == '0) && (y_pixel == '0);
        line_start  = DE && (x_pixel == '0) && (y_pixel != '0);
        w_lim       = 12'(SRC_W) << scale_q;
        h_lim       = 12'(SRC_H) << scale_q;
        in_win      = DE
                    && (x_pixel < 10'(H_ACTIVE))
                    && (y_pixel < 10'(V_ACTIVE))
                    && ({2'b0, x_pixel} < w_lim)
                    && ({2'b0, y_pixel} < h_lim);
        // A new source row begins on every line at 1:1, every even line at 2x
        row_adv     = line_start
                    && (!scale_q || !y_pixel[0])
                    && ({2'b0, y_pixel} < h_lim);

        scale_d     = frame_start ? scale_sel : scale_q;
        frame_ok_d  = frame_ok_q || frame_start;

        base_d = base_q;
        if (frame_start) begin
            base_d = '0;
        end else if (row_adv) begin
            base_d = base_q + ADDR_W'(SRC_W);
        end

        col     = scale_q ? {1'b0, x_pixel[9:1]} : x_pixel;
        active  = in_win && frame_ok_d && !tp;
        den_d   = active;
        raddr_d = active ? base_d + ADDR_W'(col) : '0;
    end

`ifdef VGA_FB_TESTPATTERN_EN
    assign dl_in = {tp, x_pixel[8:6], DE, active};
`else
    assign dl_in = {DE, active};
`endif

    vga_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (RD_LAT + 1)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   (dl_in),
        .dout  (dl_out)
    );

    always_comb begin
        de_o_d = dl_out[1];
        rgb_d  = dl_out[0] ? rgb565_to_444(rData) : 12'h000;
`ifdef VGA_FB_TESTPATTERN_EN
        if (dl_out[5]) begin
            rgb_d = dl_out[1] ? BAR_RGB[dl_out[4:2]] : 12'h000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scale_q    <= 1'b0;
            frame_ok_q <= 1'b0;
            base_q     <= '0;
            den_q      <= 1'b0;
            raddr_q    <= '0;
            de_o_q     <= 1'b0;
            rgb_q      <= '0;
        end else begin
            scale_q    <= scale_d;
            frame_ok_q <= frame_ok_d;
            base_q     <= base_d;
            den_q      <= den_d;
            raddr_q    <= raddr_d;
            de_o_q     <= de_o_d;
            rgb_q      <= rgb_d;
        end
    end

    assign den    = den_q;
    assign rAddr  = raddr_q;
    assign de_o   = de_o_q;
    assign r_port = rgb_q[11:8];
    assign g_port = rgb_q[7:4];
    assign b_port = rgb_q[3:0];

endmodule
